fixed_div_seq: RTL and testbench

//  Sequential, parametrised sign-magnitude fixed-point divider: c = a / b computed by

---
 rtl/fixed_pkg.sv | 44 ++++
 rtl/fixed_div_seq_if.sv | 24 ++
 rtl/fixed_div_step.sv | 22 ++
 rtl/fixed_div_seq.sv | 133 +++++++++++++
 tb/tb_fixed_div_seq.sv | 149 ++++++++++++++
 5 files changed

// File: rtl/fixed_pkg.sv
// Shared fixed-point definitions: default widths, divider FSM states and
// sign-magnitude helpers used by the fixed-point arithmetic blocks.
package fixed_pkg;

  localparam int FIXED_N     = 32;
  localparam int FIXED_Q     = 16;
  localparam int FIXED_MAX_W = 64;

  typedef logic [FIXED_MAX_W-1:0] fixed_word_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2,
    DONE = 2'd3
  } div_state_t;

  // Saturated sign-magnitude word of width n: magnitude all ones, sign kept.
  function automatic fixed_word_t sm_sat(input logic sign, input int n);
    fixed_word_t r;
    r = '0;
    for (int i = 0; i < FIXED_MAX_W; i++) begin
      if (i < n - 1) r[i] = 1'b1;
      else if (i == n - 1) r[i] = sign;
    end
    return r;
  endfunction

  // Clears the sign of a zero magnitude so -0 never leaves a block.
  function automatic fixed_word_t sm_normalize_zero(input fixed_word_t x, input int n);
    fixed_word_t r;
    logic        nz;
    r  = x;
    nz = 1'b0;
    for (int i = 0; i < FIXED_MAX_W; i++) begin
      if (i < n - 1) nz = nz | x[i];
    end
    for (int i = 0; i < FIXED_MAX_W; i++) begin
      if (i == n - 1 && !nz) r[i] = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/fixed_div_seq_if.sv
// Operand/result handshake bundle for the sequential fixed-point divider.
interface fixed_div_seq_if #(
  parameter int N = 32
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] c;
  logic         div_by_zero;
  logic         overflow;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, c, div_by_zero, overflow
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, c, div_by_zero, overflow
  );
endinterface

// File: rtl/fixed_div_step.sv
// One restoring-division step: shift the next dividend bit into the remainder,
// subtract the divisor when it fits, and report the resulting quotient bit.
module fixed_div_step #(
  parameter int N = 32
) (
  input  logic [N-1:0] i_rem,
  input  logic [N-2:0] i_div,
  input  logic         i_bit,
  output logic [N-1:0] o_rem,
  output logic         o_qbit
);

  logic [N-1:0] w_shift;
  logic [N-1:0] w_div_ext;

  // The incoming remainder is always below the divisor, so the shift never loses a bit.
  assign w_shift   = {i_rem[N-2:0], i_bit};
  assign w_div_ext = {1'b0, i_div};
  assign o_qbit    = (w_shift >= w_div_ext);
  assign o_rem     = o_qbit ? (w_shift - w_div_ext) : w_shift;

endmodule

// File: rtl/fixed_div_seq.sv
// Sequential sign-magnitude fixed-point divider: restoring long division, one
// quotient bit per cycle, optional round-half-away, saturation on overflow and /0.
module fixed_div_seq
  import fixed_pkg::*;
#(
  parameter int N     = FIXED_N,
  parameter int Q     = FIXED_Q,
  parameter int ROUND = 0
) (
  input  logic            clk,
  input  logic            reset,
  fixed_div_seq_if.slave  bus
);

  localparam int ITER = N - 1 + Q;
  localparam int W    = ITER;
  localparam int CW   = $clog2(ITER + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(ITER - 1);

  div_state_t   r_state;
  div_state_t   w_state_nxt;
  logic         r_sign;
  logic [N-2:0] r_div;
  logic [W-1:0] r_dvd;
  logic [W-1:0] r_quo;
  logic [N-1:0] r_rem;
  logic [CW-1:0] r_cnt;
  logic         r_zero;
  logic [N-1:0] r_c;
  logic         r_dbz;
  logic         r_ovf;

  logic         w_accept;
  logic [N-2:0] w_a_mag;
  logic [N-2:0] w_b_mag;
  logic [N-1:0] w_rem_nxt;
  logic         w_qbit;
  logic         w_round_up;
  logic [W:0]   w_quo_rnd;
  logic         w_ovf;
  logic [N-2:0] w_mag;
  logic [N-1:0] w_c_fin;

  assign w_a_mag = bus.a[N-2:0];
  assign w_b_mag = bus.b[N-2:0];

  fixed_div_step #(.N(N)) u_step (
    .i_rem  (r_rem),
    .i_div  (r_div),
    .i_bit  (r_dvd[W-1]),
    .o_rem  (w_rem_nxt),
    .o_qbit (w_qbit)
  );

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, otherwise
    // a path that skips the assignment infers a latch.
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (bus.in_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = (w_b_mag == '0) ? FIN : RUN;
        end
      end
      RUN:     if (r_cnt == '0) w_state_nxt = FIN;
      FIN:     w_state_nxt = DONE;
      DONE:    if (bus.out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Final remainder is below |b|, so 2*rem needs exactly one extra bit.
  always_comb begin
    w_round_up = (ROUND != 0) && ({r_rem, 1'b0} >= {2'b00, r_div});
    w_quo_rnd  = {1'b0, r_quo} + {{W{1'b0}}, w_round_up};
    w_ovf      = |w_quo_rnd[W:N-1];
    w_mag      = w_quo_rnd[N-2:0];
    if (w_ovf || r_zero)
      w_c_fin = N'(sm_sat(r_sign, N));
    else
      w_c_fin = N'(sm_normalize_zero(FIXED_MAX_W'({r_sign, w_mag}), N));
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    if (reset) begin
      // NOTE: the datapath is reset too, so an aborted operation leaves nothing behind.
      r_state <= IDLE;
      r_sign  <= 1'b0;
      r_div   <= '0;
      r_dvd   <= '0;
      r_quo   <= '0;
      r_rem   <= '0;
      r_cnt   <= '0;
      r_zero  <= 1'b0;
      r_c     <= '0;
      r_dbz   <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_sign <= bus.a[N-1] ^ bus.b[N-1];
        r_div  <= w_b_mag;
        r_dvd  <= W'(w_a_mag) << Q;
        r_quo  <= '0;
        r_rem  <= '0;
        r_cnt  <= CNT_LAST;
        r_zero <= (w_b_mag == '0);
      end
      if (r_state == RUN) begin
        r_rem <= w_rem_nxt;
        r_quo <= {r_quo[W-2:0], w_qbit};
        r_dvd <= r_dvd << 1;
        r_cnt <= r_cnt - CW'(1);
      end
      if (r_state == FIN) begin
        r_c   <= w_c_fin;
        r_dbz <= r_zero;
        r_ovf <= w_ovf & ~r_zero;
      end
    end
  end

  assign bus.in_ready    = (r_state == IDLE);
  assign bus.out_valid   = (r_state == DONE);
  assign bus.c           = r_c;
  assign bus.div_by_zero = r_dbz;
  assign bus.overflow    = r_ovf;

endmodule

// File: tb/tb_fixed_div_seq.sv
// Directed bench for fixed_div_seq (N=32, Q=16): a truncating and a rounding
// instance run in lockstep on the same operands.
module tb_fixed_div_seq;

  logic        clk;
  logic        reset;
  logic        drv_valid;
  logic        drv_ready;
  logic [31:0] drv_a;
  logic [31:0] drv_b;
  int          checks;
  int          failures;

  fixed_div_seq_if #(.N(32)) if_trunc ();
  fixed_div_seq_if #(.N(32)) if_round ();

  assign if_trunc.in_valid  = drv_valid;
  assign if_trunc.out_ready = drv_ready;
  assign if_trunc.a         = drv_a;
  assign if_trunc.b         = drv_b;
  assign if_round.in_valid  = drv_valid;
  assign if_round.out_ready = drv_ready;
  assign if_round.a         = drv_a;
  assign if_round.b         = drv_b;

  fixed_div_seq #(.N(32), .Q(16), .ROUND(0)) u_dut_trunc (
    .clk   (clk),
    .reset (reset),
    .bus   (if_trunc)
  );

  fixed_div_seq #(.N(32), .Q(16), .ROUND(1)) u_dut_round (
    .clk   (clk),
    .reset (reset),
    .bus   (if_round)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Latency counts the accept edge itself: ITER+2 = 49 edges, 2 on divide-by-zero.
  task automatic do_op(input string tag, input logic [31:0] op_a, input logic [31:0] op_b,
                       input logic [31:0] exp_trunc, input logic [31:0] exp_round,
                       input logic exp_dbz, input logic exp_ovf, input int exp_lat,
                       input int hold);
    int n;
    @(negedge clk);
    check({tag, "/in_ready_idle"}, 32'(if_trunc.in_ready), 32'd1);
    drv_a     = op_a;
    drv_b     = op_b;
    drv_valid = 1'b1;
    @(posedge clk);
    n = 1;
    @(negedge clk);
    drv_valid = 1'b0;
    drv_a     = 32'h1234_5678;
    drv_b     = 32'h0000_0000;
    while (!if_trunc.out_valid && n < 200) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    check({tag, "/latency"}, 32'(n), 32'(exp_lat));
    for (int i = 0; i < hold; i++) begin
      drv_valid = 1'b1;
      @(negedge clk);
    end
    drv_valid = 1'b0;
    check({tag, "/out_valid"},     32'(if_trunc.out_valid),   32'd1);
    check({tag, "/out_valid_rnd"}, 32'(if_round.out_valid),   32'd1);
    check({tag, "/in_ready_busy"}, 32'(if_trunc.in_ready),    32'd0);
    check({tag, "/c_trunc"},       if_trunc.c,                exp_trunc);
    check({tag, "/c_round"},       if_round.c,                exp_round);
    check({tag, "/dbz"},           32'(if_trunc.div_by_zero), 32'(exp_dbz));
    check({tag, "/ovf"},           32'(if_trunc.overflow),    32'(exp_ovf));
    check({tag, "/dbz_rnd"},       32'(if_round.div_by_zero), 32'(exp_dbz));
    check({tag, "/ovf_rnd"},       32'(if_round.overflow),    32'(exp_ovf));
    drv_ready = 1'b1;
    @(negedge clk);
    drv_ready = 1'b0;
    check({tag, "/out_valid_drop"}, 32'(if_trunc.out_valid), 32'd0);
    check({tag, "/in_ready_back"},  32'(if_trunc.in_ready),  32'd1);
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    reset     = 1'b1;
    drv_valid = 1'b0;
    drv_ready = 1'b0;
    drv_a     = '0;
    drv_b     = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset/in_ready",  32'(if_trunc.in_ready),    32'd1);
    check("reset/out_valid", 32'(if_trunc.out_valid),   32'd0);
    check("reset/c",         if_trunc.c,                32'h0000_0000);
    check("reset/dbz",       32'(if_trunc.div_by_zero), 32'd0);
    check("reset/ovf",       32'(if_trunc.overflow),    32'd0);
    reset = 1'b0;

    do_op("six_by_two",   32'h0006_0000, 32'h0002_0000, 32'h0003_0000, 32'h0003_0000, 1'b0, 1'b0, 49, 0);
    do_op("two_thirds",   32'h0002_0000, 32'h0003_0000, 32'h0000_AAAA, 32'h0000_AAAB, 1'b0, 1'b0, 49, 0);
    do_op("neg_thirds",   32'h8002_0000, 32'h0003_0000, 32'h8000_AAAA, 32'h8000_AAAB, 1'b0, 1'b0, 49, 0);
    do_op("div_zero",     32'h8001_0000, 32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 2,  0);
    do_op("overflow",     32'h4000_0000, 32'h0000_4000, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0, 1'b1, 49, 0);
    do_op("neg_zero",     32'h8000_0000, 32'h0001_0000, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 49, 0);
    // Exactly half an LSB: truncation yields zero (sign dropped), rounding yields -1 LSB.
    do_op("half_lsb",     32'h8000_0001, 32'h0002_0000, 32'h0000_0000, 32'h8000_0001, 1'b0, 1'b0, 49, 0);
    do_op("hold_stall",   32'h0001_0000, 32'h8004_0000, 32'h8000_4000, 32'h8000_4000, 1'b0, 1'b0, 49, 10);

    // Abort in the middle of RUN; no result may appear afterwards.
    @(negedge clk);
    drv_a     = 32'h0006_0000;
    drv_b     = 32'h0002_0000;
    drv_valid = 1'b1;
    @(negedge clk);
    drv_valid = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort/out_valid", 32'(if_trunc.out_valid), 32'd0);
    check("abort/in_ready",  32'(if_trunc.in_ready),  32'd1);
    check("abort/c",         if_trunc.c,              32'h0000_0000);
    repeat (60) @(negedge clk);
    check("abort/no_result", 32'(if_trunc.out_valid), 32'd0);

    do_op("after_abort",  32'h0006_0000, 32'h0002_0000, 32'h0003_0000, 32'h0003_0000, 1'b0, 1'b0, 49, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
